// File: rtl/cl_axi_trace_mon.sv
// cl_axi_trace_mon: passive AXI4 tap for the PCIS DMA path.
// Counts handshakes on all five channels and records AW/AR address events
// into a circular trace RAM around a masked address trigger.
// Optional build macro CL_AXI_TRACE_TS_EN appends a 32-bit timestamp to
// every trace entry; without it entries end at the address MSB.
module cl_axi_trace_mon #(
   parameter int ADDR_W = 64,
   parameter int ID_W   = 6,
   parameter int DEPTH  = 512,
   parameter int PW     = $clog2(DEPTH),
`ifdef CL_AXI_TRACE_TS_EN
   localparam int EW    = 1 + ID_W + 8 + ADDR_W + 32
`else
   localparam int EW    = 1 + ID_W + 8 + ADDR_W
`endif
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic              mon_awvalid,
   input  logic              mon_awready,
   input  logic [ADDR_W-1:0] mon_awaddr,
   input  logic [ID_W-1:0]   mon_awid,
   input  logic [7:0]        mon_awlen,
   input  logic              mon_arvalid,
   input  logic              mon_arready,
   input  logic [ADDR_W-1:0] mon_araddr,
   input  logic [ID_W-1:0]   mon_arid,
   input  logic [7:0]        mon_arlen,
   input  logic              mon_wvalid,
   input  logic              mon_wready,
   input  logic              mon_rvalid,
   input  logic              mon_rready,
   input  logic              mon_bvalid,
   input  logic              mon_bready,
   input  logic              ctl_arm,
   input  logic              ctl_clear,
   input  logic [ADDR_W-1:0] trig_addr,
   input  logic [ADDR_W-1:0] trig_mask,
   input  logic [PW-1:0]     post_count,
   input  logic [PW-1:0]     rd_idx,
   output logic [EW-1:0]     rd_data,
   output logic [31:0]       cnt_aw,
   output logic [31:0]       cnt_ar,
   output logic [31:0]       cnt_w,
   output logic [31:0]       cnt_r,
   output logic [31:0]       cnt_b,
   output logic [15:0]       cnt_drop,
   output logic [1:0]        st_state,
   output logic [PW-1:0]     st_trig_idx,
   output logic [PW-1:0]     st_wr_ptr,
   output logic              st_wrapped
);

   localparam int AOFF = 1 + ID_W + 8;

   typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, DONE = 2'd3} state_t;

   state_t          state;
   logic [EW-1:0]   ram [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   trig_idx;
   logic [PW-1:0]   post_left;
   logic            wrapped;
   logic            skid_vld;
   logic [EW-1:0]   skid_q;

   logic            aw_hs, ar_hs, w_hs, r_hs, b_hs;
   logic            recording;
   logic [EW-1:0]   aw_ent, ar_ent;
   logic            wr_en;
   logic [EW-1:0]   wr_ent;
   logic            skid_load;
   logic [EW-1:0]   skid_nxt;
   logic            drop_evt;
   logic            trig_hit;

   assign aw_hs = mon_awvalid & mon_awready;
   assign ar_hs = mon_arvalid & mon_arready;
   assign w_hs  = mon_wvalid & mon_wready;
   assign r_hs  = mon_rvalid & mon_rready;
   assign b_hs  = mon_bvalid & mon_bready;

   // An arm pulse restarts capture, so events in that cycle are not recorded
   assign recording = ((state == ARMED) || (state == CAPTURE)) && !ctl_arm;

`ifdef CL_AXI_TRACE_TS_EN
   logic [31:0] ts_q;

   // Free-running timestamp stamped into entries at handshake time
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) ts_q <= 32'd0;
      else          ts_q <= ts_q + 32'd1;
   end

   assign aw_ent = {ts_q, mon_awaddr, mon_awlen, mon_awid, 1'b0};
   assign ar_ent = {ts_q, mon_araddr, mon_arlen, mon_arid, 1'b1};
`else
   assign aw_ent = {mon_awaddr, mon_awlen, mon_awid, 1'b0};
   assign ar_ent = {mon_araddr, mon_arlen, mon_arid, 1'b1};
`endif

   // Pick this cycle's single RAM write: skid first, then AW, then AR; a full skid can only be refilled by AW
   always_comb begin
      wr_en     = 1'b0;
      wr_ent    = aw_ent;
      skid_load = 1'b0;
      skid_nxt  = aw_ent;
      drop_evt  = 1'b0;
      if (recording) begin
         if (skid_vld) begin
            wr_en     = 1'b1;
            wr_ent    = skid_q;
            skid_load = aw_hs;
            skid_nxt  = aw_ent;
            drop_evt  = ar_hs;
         end else if (aw_hs) begin
            wr_en     = 1'b1;
            wr_ent    = aw_ent;
            skid_load = ar_hs;
            skid_nxt  = ar_ent;
         end else if (ar_hs) begin
            wr_en     = 1'b1;
            wr_ent    = ar_ent;
         end
      end
   end

   assign trig_hit = (((wr_ent[AOFF +: ADDR_W] ^ trig_addr) & trig_mask) == '0);

   // Capture FSM with write pointer, wrap flag, trigger index and skid slot
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         trig_idx  <= '0;
         post_left <= '0;
         wrapped   <= 1'b0;
         skid_vld  <= 1'b0;
         skid_q    <= '0;
      end else if (ctl_arm) begin
         state     <= ARMED;
         wr_ptr    <= '0;
         trig_idx  <= '0;
         post_left <= '0;
         wrapped   <= 1'b0;
         skid_vld  <= 1'b0;
      end else if ((state == ARMED) || (state == CAPTURE)) begin
         skid_vld <= skid_load;
         if (skid_load) skid_q <= skid_nxt;
         if (wr_en) begin
            wr_ptr <= wr_ptr + PW'(1);
            if (wr_ptr == PW'(DEPTH - 1)) wrapped <= 1'b1;
            if (state == ARMED) begin
               if (trig_hit) begin
                  trig_idx <= wr_ptr;
                  if (post_count == '0) begin
                     state    <= DONE;
                     skid_vld <= 1'b0;
                  end else begin
                     state     <= CAPTURE;
                     post_left <= post_count;
                  end
               end
            end else begin
               post_left <= post_left - PW'(1);
               if (post_left == PW'(1)) begin
                  state    <= DONE;
                  skid_vld <= 1'b0;
               end
            end
         end
      end
   end

   // Saturating handshake and drop counters; clear beats a same-cycle increment
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         cnt_aw   <= '0;
         cnt_ar   <= '0;
         cnt_w    <= '0;
         cnt_r    <= '0;
         cnt_b    <= '0;
         cnt_drop <= '0;
      end else if (ctl_clear) begin
         cnt_aw   <= '0;
         cnt_ar   <= '0;
         cnt_w    <= '0;
         cnt_r    <= '0;
         cnt_b    <= '0;
         cnt_drop <= '0;
      end else begin
         if (aw_hs && (cnt_aw != 32'hFFFF_FFFF)) cnt_aw <= cnt_aw + 32'd1;
         if (ar_hs && (cnt_ar != 32'hFFFF_FFFF)) cnt_ar <= cnt_ar + 32'd1;
         if (w_hs && (cnt_w != 32'hFFFF_FFFF))   cnt_w  <= cnt_w + 32'd1;
         if (r_hs && (cnt_r != 32'hFFFF_FFFF))   cnt_r  <= cnt_r + 32'd1;
         if (b_hs && (cnt_b != 32'hFFFF_FFFF))   cnt_b  <= cnt_b + 32'd1;
         if (drop_evt && (cnt_drop != 16'hFFFF)) cnt_drop <= cnt_drop + 16'd1;
      end
   end

   // Trace RAM write port; contents are not reset
   always_ff @(posedge aclk) begin
      if (wr_en) ram[wr_ptr] <= wr_ent;
   end

   // Registered read port; a same-cycle write to the slot returns the old data
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) rd_data <= '0;
      else          rd_data <= ram[rd_idx];
   end

   assign st_state    = state;
   assign st_trig_idx = trig_idx;
   assign st_wr_ptr   = wr_ptr;
   assign st_wrapped  = wrapped;

endmodule

// File: tb/tb_cl_axi_trace_mon.sv
// Testbench for cl_axi_trace_mon (DEPTH=4). Stimulus pushes expected values
// into a scoreboard queue; a negedge monitor pops and compares them.
module tb_cl_axi_trace_mon;

   localparam int ADDR_W = 64;
   localparam int ID_W   = 6;
   localparam int DEPTH  = 4;
   localparam int PW     = 2;
   localparam int NOTS   = 1 + ID_W + 8 + ADDR_W;
`ifdef CL_AXI_TRACE_TS_EN
   localparam int EW     = NOTS + 32;
`else
   localparam int EW     = NOTS;
`endif

   localparam int K_STATE = 0;
   localparam int K_TRIG  = 1;
   localparam int K_WRPTR = 2;
   localparam int K_WRAP  = 3;
   localparam int K_AW    = 4;
   localparam int K_AR    = 5;
   localparam int K_W     = 6;
   localparam int K_R     = 7;
   localparam int K_B     = 8;
   localparam int K_DROP  = 9;
   localparam int K_RD    = 10;

   typedef struct {
      int           kind;
      string        name;
      logic [127:0] exp;
   } item_t;

   logic              aclk = 1'b0;
   logic              aresetn = 1'b0;
   logic              mon_awvalid = 1'b0, mon_arvalid = 1'b0;
   logic              mon_awready = 1'b1, mon_arready = 1'b1;
   logic [ADDR_W-1:0] mon_awaddr = '0, mon_araddr = '0;
   logic [ID_W-1:0]   mon_awid = 6'h11, mon_arid = 6'h22;
   logic [7:0]        mon_awlen = 8'd3, mon_arlen = 8'd7;
   logic              mon_wvalid = 1'b0, mon_rvalid = 1'b0, mon_bvalid = 1'b0;
   logic              mon_wready = 1'b1, mon_rready = 1'b1, mon_bready = 1'b1;
   logic              ctl_arm = 1'b0, ctl_clear = 1'b0;
   logic [ADDR_W-1:0] trig_addr = 64'h4000;
   logic [ADDR_W-1:0] trig_mask = 64'hFFFF_FFFF_FFFF_F000;
   logic [PW-1:0]     post_count = 2'd3;
   logic [PW-1:0]     rd_idx = '0;
   logic [EW-1:0]     rd_data;
   logic [31:0]       cnt_aw, cnt_ar, cnt_w, cnt_r, cnt_b;
   logic [15:0]       cnt_drop;
   logic [1:0]        st_state;
   logic [PW-1:0]     st_trig_idx, st_wr_ptr;
   logic              st_wrapped;

   item_t sbq[$];
   logic  chk_go = 1'b0;
   int    total = 0;
   int    bad = 0;

   cl_axi_trace_mon #(.ADDR_W(ADDR_W), .ID_W(ID_W), .DEPTH(DEPTH)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .mon_awvalid(mon_awvalid), .mon_awready(mon_awready), .mon_awaddr(mon_awaddr),
      .mon_awid(mon_awid), .mon_awlen(mon_awlen),
      .mon_arvalid(mon_arvalid), .mon_arready(mon_arready), .mon_araddr(mon_araddr),
      .mon_arid(mon_arid), .mon_arlen(mon_arlen),
      .mon_wvalid(mon_wvalid), .mon_wready(mon_wready),
      .mon_rvalid(mon_rvalid), .mon_rready(mon_rready),
      .mon_bvalid(mon_bvalid), .mon_bready(mon_bready),
      .ctl_arm(ctl_arm), .ctl_clear(ctl_clear),
      .trig_addr(trig_addr), .trig_mask(trig_mask), .post_count(post_count),
      .rd_idx(rd_idx), .rd_data(rd_data),
      .cnt_aw(cnt_aw), .cnt_ar(cnt_ar), .cnt_w(cnt_w), .cnt_r(cnt_r), .cnt_b(cnt_b),
      .cnt_drop(cnt_drop), .st_state(st_state), .st_trig_idx(st_trig_idx),
      .st_wr_ptr(st_wr_ptr), .st_wrapped(st_wrapped)
   );

   always #5 aclk = ~aclk;

   // Expected trace entry without timestamp: AW carries id 0x11/len 3, AR id 0x22/len 7
   function automatic logic [NOTS-1:0] mkEnt(input logic is_ar, input logic [ADDR_W-1:0] a);
      if (is_ar) return {a, 8'd7, 6'h22, 1'b1};
      return {a, 8'd3, 6'h11, 1'b0};
   endfunction

   function automatic logic [127:0] pickActual(input int kind);
      case (kind)
         K_STATE: return 128'(st_state);
         K_TRIG:  return 128'(st_trig_idx);
         K_WRPTR: return 128'(st_wr_ptr);
         K_WRAP:  return 128'(st_wrapped);
         K_AW:    return 128'(cnt_aw);
         K_AR:    return 128'(cnt_ar);
         K_W:     return 128'(cnt_w);
         K_R:     return 128'(cnt_r);
         K_B:     return 128'(cnt_b);
         K_DROP:  return 128'(cnt_drop);
         default: return 128'(rd_data[NOTS-1:0]);
      endcase
   endfunction

   // Monitor: on each negedge while checking is enabled, drain and compare the scoreboard
   initial begin
      item_t it;
      logic [127:0] act;
      forever begin
         @(negedge aclk);
         if (chk_go) begin
            while (sbq.size() > 0) begin
               it = sbq.pop_front();
               act = pickActual(it.kind);
               total++;
               if (act !== it.exp) begin
                  bad++;
                  $display("[TB] FAIL %s actual=%0h required=%0h", it.name, act, it.exp);
               end
            end
         end
      end
   end

   task automatic expectVal(input int kind, input string name, input logic [127:0] val);
      item_t it;
      it.kind = kind;
      it.name = name;
      it.exp  = val;
      sbq.push_back(it);
   endtask

   // Let the monitor consume the queued expectations within a bounded wait
   task automatic checkOutput();
      chk_go = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge aclk);
         #1;
         if (sbq.size() == 0) break;
      end
      if (sbq.size() != 0) begin
         $display("[TB] FAIL monitor_timeout actual=%0d pending required=0", sbq.size());
         total += sbq.size();
         bad += sbq.size();
         sbq.delete();
      end
      chk_go = 1'b0;
   endtask

   // Drive one cycle of bus/control activity, then return everything to idle
   task automatic applyStimulus(input logic aw, input logic [ADDR_W-1:0] awa,
                                input logic ar, input logic [ADDR_W-1:0] ara,
                                input logic [2:0] wrb, input logic clr, input logic arm);
      mon_awvalid = aw;
      mon_awaddr  = awa;
      mon_arvalid = ar;
      mon_araddr  = ara;
      mon_wvalid  = wrb[2];
      mon_rvalid  = wrb[1];
      mon_bvalid  = wrb[0];
      ctl_clear   = clr;
      ctl_arm     = arm;
      @(posedge aclk);
      #1;
      mon_awvalid = 1'b0;
      mon_arvalid = 1'b0;
      mon_wvalid  = 1'b0;
      mon_rvalid  = 1'b0;
      mon_bvalid  = 1'b0;
      ctl_clear   = 1'b0;
      ctl_arm     = 1'b0;
   endtask

   task automatic readCheck(input logic [PW-1:0] idx, input logic [NOTS-1:0] exp, input string name);
      rd_idx = idx;
      @(posedge aclk);
      #1;
      expectVal(K_RD, name, 128'(exp));
      checkOutput();
   endtask

   // Directed sequence
   initial begin
      logic [ADDR_W-1:0] a;
`ifdef CL_AXI_TRACE_TS_EN
      logic [31:0] ts0, ts1;
`endif
      repeat (3) @(posedge aclk);
      #1;
      expectVal(K_STATE, "rst_state", 0);
      expectVal(K_WRPTR, "rst_wrptr", 0);
      expectVal(K_AW, "rst_cnt_aw", 0);
      expectVal(K_DROP, "rst_drop", 0);
      expectVal(K_WRAP, "rst_wrap", 0);
      expectVal(K_RD, "rst_rd_data", 0);
      checkOutput();
      @(posedge aclk);
      #1;
      aresetn = 1'b1;

      // Idle: handshakes counted but never recorded
      applyStimulus(1'b1, 64'h4000, 1'b0, '0, 3'b011, 1'b0, 1'b0);
      expectVal(K_AW, "idle_cnt_aw", 1);
      expectVal(K_R, "idle_cnt_r", 1);
      expectVal(K_B, "idle_cnt_b", 1);
      expectVal(K_STATE, "idle_state", 0);
      expectVal(K_WRPTR, "idle_wrptr", 0);
      checkOutput();

      // Trigger run: AW at 0x4010 is entry 2, three further ARs end capture
      applyStimulus(1'b0, '0, 1'b0, '0, 3'b000, 1'b1, 1'b0);
      applyStimulus(1'b0, '0, 1'b0, '0, 3'b000, 1'b0, 1'b1);
      expectVal(K_STATE, "arm_state", 1);
      expectVal(K_AW, "clear_cnt_aw", 0);
      checkOutput();
      applyStimulus(1'b0, '0, 1'b1, 64'h1000, 3'b000, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b1, 64'h2000, 3'b000, 1'b0, 1'b0);
      applyStimulus(1'b1, 64'h4010, 1'b0, '0, 3'b000, 1'b0, 1'b0);
      expectVal(K_STATE, "trig_capture", 2);
      expectVal(K_TRIG, "trig_idx", 2);
      checkOutput();
      applyStimulus(1'b0, '0, 1'b1, 64'h5000, 3'b000, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b1, 64'h6000, 3'b000, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b1, 64'h7000, 3'b000, 1'b0, 1'b0);
      expectVal(K_STATE, "trig_done", 3);
      checkOutput();
      applyStimulus(1'b0, '0, 1'b1, 64'h8000, 3'b000, 1'b0, 1'b0);
      expectVal(K_STATE, "done_hold", 3);
      expectVal(K_WRPTR, "trig_wrptr", 2);
      expectVal(K_WRAP, "trig_wrap", 1);
      expectVal(K_AR, "trig_cnt_ar", 6);
      expectVal(K_AW, "trig_cnt_aw", 1);
      checkOutput();
      readCheck(2'd2, mkEnt(1'b0, 64'h4010), "trig_entry2");
      readCheck(2'd1, mkEnt(1'b1, 64'h7000), "trig_entry5");
      readCheck(2'd3, mkEnt(1'b1, 64'h5000), "trig_entry3");

      // Wrap: six non-matching ARs into four slots
      applyStimulus(1'b0, '0, 1'b0, '0, 3'b000, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) begin
         a = 64'hA000 + 64'(i) * 64'h1000;
         applyStimulus(1'b0, '0, 1'b1, a, 3'b000, 1'b0, 1'b0);
      end
      expectVal(K_STATE, "wrap_state", 1);
      expectVal(K_WRAP, "wrap_flag", 1);
      expectVal(K_WRPTR, "wrap_wrptr", 2);
      expectVal(K_AR, "wrap_cnt_ar", 12);
      checkOutput();
      readCheck(2'd0, mkEnt(1'b1, 64'hE000), "wrap_entry0");
      readCheck(2'd1, mkEnt(1'b1, 64'hF000), "wrap_entry1");

      // Two back-to-back AW+AR collisions: AW, AR, AW stored and one AR lost
      applyStimulus(1'b0, '0, 1'b0, '0, 3'b000, 1'b0, 1'b1);
      applyStimulus(1'b1, 64'h100, 1'b1, 64'h200, 3'b000, 1'b0, 1'b0);
      applyStimulus(1'b1, 64'h300, 1'b1, 64'h400, 3'b000, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b0, '0, 3'b000, 1'b0, 1'b0);
      expectVal(K_WRPTR, "coll_wrptr", 3);
      expectVal(K_DROP, "coll_drop", 1);
      expectVal(K_WRAP, "coll_wrap", 0);
      expectVal(K_STATE, "coll_state", 1);
      checkOutput();
      readCheck(2'd0, mkEnt(1'b0, 64'h100), "coll_entry0");
      readCheck(2'd1, mkEnt(1'b1, 64'h200), "coll_entry1");
      readCheck(2'd2, mkEnt(1'b0, 64'h300), "coll_entry2");

      // 300 W beats with a clear on the same cycle as beat index 200
      for (int i = 0; i < 300; i++)
         applyStimulus(1'b0, '0, 1'b0, '0, 3'b100, (i == 200), 1'b0);
      expectVal(K_W, "clear_cnt_w", 99);
      expectVal(K_DROP, "clear_drop", 0);
      expectVal(K_AR, "clear_cnt_ar", 0);
      checkOutput();

      // Arm with a matching AR in the same cycle: counted, not recorded
      applyStimulus(1'b0, '0, 1'b1, 64'h4000, 3'b000, 1'b0, 1'b1);
      expectVal(K_STATE, "armev_state", 1);
      expectVal(K_WRPTR, "armev_wrptr", 0);
      expectVal(K_AR, "armev_cnt_ar", 1);
      checkOutput();
      applyStimulus(1'b0, '0, 1'b1, 64'h4abc, 3'b000, 1'b0, 1'b0);
      expectVal(K_STATE, "armev_trig_state", 2);
      expectVal(K_TRIG, "armev_trig_idx", 0);
      expectVal(K_WRPTR, "armev_trig_wrptr", 1);
      checkOutput();

`ifdef CL_AXI_TRACE_TS_EN
      // Two events 15 cycles apart carry timestamps 15 apart
      applyStimulus(1'b0, '0, 1'b0, '0, 3'b000, 1'b0, 1'b1);
      applyStimulus(1'b0, '0, 1'b1, 64'h9000, 3'b000, 1'b0, 1'b0);
      repeat (14) @(posedge aclk);
      #1;
      applyStimulus(1'b0, '0, 1'b1, 64'h9100, 3'b000, 1'b0, 1'b0);
      rd_idx = 2'd0;
      @(posedge aclk);
      #1;
      ts0 = rd_data[EW-1 -: 32];
      rd_idx = 2'd1;
      @(posedge aclk);
      #1;
      ts1 = rd_data[EW-1 -: 32];
      total++;
      if ((ts1 - ts0) !== 32'd15) begin
         bad++;
         $display("[TB] FAIL ts_delta actual=%0d required=15", ts1 - ts0);
      end
`endif

      repeat (2) @(posedge aclk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
